// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit accumulator CPU.
// Holds the opcodes (ir[7:4]), the ALU select codes and the sequencer state encodings.
package cpu_pkg;

  // Opcodes. 4'hD and 4'hE are undefined and execute as NOP.
  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLdi = 4'h1;
  localparam logic [3:0] OpLda = 4'h2;
  localparam logic [3:0] OpSta = 4'h3;
  localparam logic [3:0] OpAnd = 4'h4;
  localparam logic [3:0] OpOr  = 4'h5;
  localparam logic [3:0] OpAdd = 4'h6;
  localparam logic [3:0] OpSub = 4'h7;
  localparam logic [3:0] OpNot = 4'h8;
  localparam logic [3:0] OpInc = 4'h9;
  localparam logic [3:0] OpDec = 4'hA;
  localparam logic [3:0] OpJmp = 4'hB;
  localparam logic [3:0] OpJz  = 4'hC;
  localparam logic [3:0] OpUd0 = 4'hD;
  localparam logic [3:0] OpUd1 = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;

  // ALU select codes.
  localparam logic [2:0] AluPass = 3'b000;
  localparam logic [2:0] AluAnd  = 3'b001;
  localparam logic [2:0] AluOr   = 3'b010;
  localparam logic [2:0] AluAdd  = 3'b011;
  localparam logic [2:0] AluSub  = 3'b100;
  localparam logic [2:0] AluNot  = 3'b101;
  localparam logic [2:0] AluInc  = 3'b110;
  localparam logic [2:0] AluDec  = 3'b111;

  // Sequencer states.
  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StFetch   = 3'd1;
  localparam logic [2:0] StDecode  = 3'd2;
  localparam logic [2:0] StOperand = 3'd3;
  localparam logic [2:0] StMemRd   = 3'd4;
  localparam logic [2:0] StMemWr   = 3'd5;
  localparam logic [2:0] StExecute = 3'd6;
  localparam logic [2:0] StHalt    = 3'd7;

endpackage

// File: rtl/alu.sv
// 8-bit combinational ALU, modulo-256 arithmetic, no flags.
// Ports: a, b - operands; sel - operation select; y - result.
module alu
  import cpu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] sel,
  output logic [7:0] y
);

  always_comb begin
    y = 8'h00;
    case (sel)
      AluPass: y = a;
      AluAnd:  y = a & b;
      AluOr:   y = a | b;
      AluAdd:  y = a + b;
      AluSub:  y = a - b;
      AluNot:  y = ~a;
      AluInc:  y = a + 8'h01;
      AluDec:  y = a - 8'h01;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Owns pc, ir, opr, mdr, acc and zero; drives the ALU and a req/ack memory port.
// Ports: clk, rst_n (async, active-low); mem_req/mem_we/mem_addr/mem_wdata to memory,
//        mem_rdata/mem_ack from memory; pc_o, acc_o, zero, halted status.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] acc_o,
  output logic              zero,
  output logic              halted
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  // Only the opcode nibble is kept; ir[3:0] carries no meaning.
  logic [3:0]        ir_q, ir_d;
  logic [DATA_W-1:0] opr_q, opr_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              zero_q, zero_d;

  logic [7:0] alu_a, alu_b, alu_y;
  logic [2:0] alu_sel;

  assign pc_inc = pc_q + ADDR_W'(1);

  alu u_alu (
    .a   (alu_a),
    .b   (alu_b),
    .sel (alu_sel),
    .y   (alu_y)
  );

  // ALU steering is a pure function of the opcode; only EXECUTE consumes it.
  always_comb begin
    alu_sel = AluPass;
    alu_a   = acc_q;
    alu_b   = mdr_q;
    case (ir_q)
      OpLdi: alu_a = opr_q;
      OpLda: alu_a = mdr_q;
      OpAnd: alu_sel = AluAnd;
      OpOr:  alu_sel = AluOr;
      OpAdd: alu_sel = AluAdd;
      OpSub: alu_sel = AluSub;
      OpNot: alu_sel = AluNot;
      OpInc: alu_sel = AluInc;
      OpDec: alu_sel = AluDec;
      default: alu_sel = AluPass;
    endcase
  end

  // Memory port decoded from state so it holds steady until the ack arrives.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      StFetch, StOperand: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
      end
      StMemRd: begin
        mem_req  = 1'b1;
        mem_addr = ADDR_W'(opr_q);
      end
      StMemWr: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ADDR_W'(opr_q);
        mem_wdata = acc_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    opr_d   = opr_q;
    mdr_d   = mdr_q;
    acc_d   = acc_q;
    zero_d  = zero_q;
    case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (mem_ack) begin
          ir_d    = mem_rdata[7:4];
          pc_d    = pc_inc;
          state_d = StDecode;
        end
      end
      StDecode: begin
        case (ir_q)
          OpNop, OpUd0, OpUd1:  state_d = StFetch;
          OpNot, OpInc, OpDec:  state_d = StExecute;
          OpHlt:                state_d = StHalt;
          default:              state_d = StOperand;
        endcase
      end
      StOperand: begin
        if (mem_ack) begin
          opr_d = mem_rdata;
          case (ir_q)
            OpLdi: begin
              pc_d    = pc_inc;
              state_d = StExecute;
            end
            OpJmp: begin
              pc_d    = ADDR_W'(mem_rdata);
              state_d = StFetch;
            end
            OpJz: begin
              pc_d    = zero_q ? ADDR_W'(mem_rdata) : pc_inc;
              state_d = StFetch;
            end
            OpSta: begin
              pc_d    = pc_inc;
              state_d = StMemWr;
            end
            default: begin
              pc_d    = pc_inc;
              state_d = StMemRd;
            end
          endcase
        end
      end
      StMemRd: begin
        if (mem_ack) begin
          mdr_d   = mem_rdata;
          state_d = StExecute;
        end
      end
      StMemWr: begin
        if (mem_ack) state_d = StFetch;
      end
      StExecute: begin
        acc_d   = alu_y;
        zero_d  = (alu_y == 8'h00);
        state_d = StFetch;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
      opr_q   <= '0;
      mdr_q   <= '0;
      acc_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opr_q   <= opr_d;
      mdr_q   <= mdr_d;
      acc_q   <= acc_d;
      zero_q  <= zero_d;
    end
  end

  assign pc_o   = pc_q;
  assign acc_o  = acc_q;
  assign zero   = zero_q;
  assign halted = (state_q == StHalt);

endmodule
